sensor_window_averager: RTL and testbench
=========================================

Name: sensor_window_averager

Overview:
- Downstream consumer of the synchronised sensor byte stream.
- Accumulates a fixed window of 2^LOG2_N qualified samples and emits their truncated mean through a one-entry valid/ready output buffer.
- Feeds the logging/telemetry path.
- Counts windows lost to downstream back-pressure.

Parameters:
- DATA_W, 8: sample and average width.
- LOG2_N, 3: window size exponent; window = 2^LOG2_N samples; legal range 0..8.
- DROP_CNT_W, 8: width of the saturating drop counter.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- sample_in  input  DATA_W  synchronised sensor byte from the input stage.
- sample_en  input  1  qualifies sample_in for the current cycle.
- avg_out  output  DATA_W  window mean, floor(sum / 2^LOG2_N).
- avg_valid  output  1  avg_out holds an unconsumed result.
- avg_ready  input  1  consumer accepts avg_out this cycle.
- busy  output  1  partial window in progress (sample count != 0).
- drop_cnt  output  DROP_CNT_W  windows discarded because the buffer was full; saturates at all-ones.

Behaviour:
- Reset (clk edge with reset=1):
  - acc, cnt, avg_out, avg_valid, busy and drop_cnt all go to 0.
  - A partial window is discarded.
  - reset overrides every other input in that cycle.
- Accumulator: ACC_W = DATA_W + LOG2_N bits, so it never overflows. cnt is LOG2_N bits wide.
- Accumulator FSM, IDLE (cnt==0) / FILL (cnt!=0):
  - sample_en=0: acc and cnt hold.
  - sample_en=1 and cnt != 2^LOG2_N-1: acc += sample_in, cnt++, state becomes FILL.
  - sample_en=1 and cnt == 2^LOG2_N-1 (final sample): result = (acc + sample_in) >> LOG2_N, truncated. acc and cnt clear to 0 and state returns to IDLE.
  - busy = (cnt != 0), registered.
- Output buffer FSM, EMPTY / FULL:
  - A result loads when avg_valid==0, or when avg_valid==1 && avg_ready==1 in the same cycle.
  - On load, avg_out takes the result and avg_valid=1 on the next edge. Latency: result visible 1 cycle after the final sample's edge.
  - While avg_valid && !avg_ready, avg_out is stable.
  - Handshake with no completion: avg_valid falls to 0 next cycle.
  - Handshake plus completion in the same cycle: new value loads and avg_valid stays 1, with no bubble and no drop.
  - Completion while FULL and avg_ready=0: result is discarded, avg_out unchanged, drop_cnt += 1 unless already all-ones.
- LOG2_N=0: every qualified sample completes a window, giving pass-through with 1-cycle latency.
- Non-consecutive sample_en pulses are fine: the window counts qualified samples, not cycles.

Optional Feature:
- Macro: SENSOR_WINDOW_MINMAX_EN.
- Defined:
  - Adds outputs min_out and max_out (DATA_W each).
  - Both track the minimum and maximum of the window, including the final sample.
  - They load into the output buffer together with avg_out and obey the same hold and drop rules.
  - Both reset to 0.
  - Running min/max re-seed from the first sample of each window.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package sensor_pkg:
  - SENSOR_DATA_W = 8.
  - typedef sensor_sample_t (logic [SENSOR_DATA_W-1:0]).
  - typedef struct window_result_t {avg; min; max}; min/max fields conditional on the macro.
- Sub-module sensor_window_accum: acc/cnt FSM, min/max tracking, and a one-cycle done strobe with window_result_t.
- Top level: output buffer, handshake and drop counter.

Test Plan:
- Reset, then 8 consecutive samples 10,20,...,80 with avg_ready=1 -> one cycle after the 8th sample, avg_valid=1 and avg_out=45; drop_cnt=0.
- Samples 8×255 -> avg_out=255; no overflow (acc reached 2040 within 11 bits). Samples 1,1,1,1,1,1,1,2 -> avg_out=1 (truncation).
- Hold avg_ready=0 across three completed windows -> first result held stable; drop_cnt=2. Assert avg_ready -> avg_valid falls next cycle.
- Window completes in the same cycle avg_ready=1 while FULL -> new avg_out loads, avg_valid stays 1, drop_cnt unchanged.
- Assert reset after 5 of 8 samples -> busy=0 next cycle. Then 8 samples of 100 -> avg_out=100, with no contamination from the partial window.
- With SENSOR_WINDOW_MINMAX_EN defined, samples 7,3,9,5,5,5,5,5 -> min_out=3, max_out=9, avg_out=5.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared types for the sensor window averager. Optional min/max fields are
// present only when SENSOR_WINDOW_MINMAX_EN is defined.
package sensor_pkg;

  localparam int SENSOR_DATA_W = 8;

  typedef logic [SENSOR_DATA_W-1:0] sensor_sample_t;

  typedef struct packed {
    sensor_sample_t avg;
`ifdef SENSOR_WINDOW_MINMAX_EN
    sensor_sample_t min;
    sensor_sample_t max;
`endif
  } window_result_t;

  typedef enum logic {
    ACC_IDLE = 1'b0,
    ACC_FILL = 1'b1
  } acc_state_e;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

`ifdef SENSOR_WINDOW_MINMAX_EN
  function automatic sensor_sample_t sample_min(input sensor_sample_t a, input sensor_sample_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic sensor_sample_t sample_max(input sensor_sample_t a, input sensor_sample_t b);
    return (a > b) ? a : b;
  endfunction
`endif

endpackage

// File: rtl/sensor_window_accum.sv
// Window accumulator: sums 2^LOG2_N qualified samples and strobes done_o with
// the window result in the cycle the final sample is presented.
module sensor_window_accum
  import sensor_pkg::*;
#(
  parameter int LOG2_N = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  sensor_sample_t sample_in_i,
  input  logic           sample_en_i,
  output logic           busy_o,
  output logic           done_o,
  output window_result_t result_o
);

  localparam int ACC_W = SENSOR_DATA_W + LOG2_N;
  // A zero-bit counter is not legal, so LOG2_N=0 keeps one bit pinned at 0.
  localparam int CNT_W = (LOG2_N == 0) ? 1 : LOG2_N;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_s;
`ifdef SENSOR_WINDOW_MINMAX_EN
  sensor_sample_t   min_q, min_d, max_q, max_d, win_min_s, win_max_s;
`endif

  assign sum_s  = acc_q + ACC_W'(sample_in_i);
  assign last_s = (cnt_q == CNT_LAST);
  assign busy_o = (state_q == ACC_FILL);

  // Next-state for count/sum plus the combinational window result.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    done_o   = 1'b0;
    result_o = '0;
    result_o.avg = sum_s[ACC_W-1 -: SENSOR_DATA_W];
`ifdef SENSOR_WINDOW_MINMAX_EN
    min_d = min_q;
    max_d = max_q;
    case (state_q)
      ACC_IDLE: begin
        win_min_s = sample_in_i;
        win_max_s = sample_in_i;
      end
      ACC_FILL: begin
        win_min_s = sample_min(min_q, sample_in_i);
        win_max_s = sample_max(max_q, sample_in_i);
      end
      default: begin
        win_min_s = sample_in_i;
        win_max_s = sample_in_i;
      end
    endcase
    result_o.min = win_min_s;
    result_o.max = win_max_s;
`endif
    if (sample_en_i) begin
      if (last_s) begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ACC_IDLE;
        done_o  = 1'b1;
      end else begin
        acc_d   = sum_s;
        cnt_d   = cnt_q + 1'b1;
        state_d = ACC_FILL;
`ifdef SENSOR_WINDOW_MINMAX_EN
        min_d   = win_min_s;
        max_d   = win_max_s;
`endif
      end
    end else begin
      state_d = state_q;
    end
  end

  // State, sum and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACC_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
`ifdef SENSOR_WINDOW_MINMAX_EN
      min_q   <= '0;
      max_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`ifdef SENSOR_WINDOW_MINMAX_EN
      min_q   <= min_d;
      max_q   <= max_d;
`endif
    end
  end

endmodule

// File: rtl/sensor_window_averager.sv
// Window averager top: one-entry valid/ready result buffer and saturating
// drop counter. Define SENSOR_WINDOW_MINMAX_EN to add min_out/max_out.
module sensor_window_averager
  import sensor_pkg::*;
#(
  parameter int DATA_W     = SENSOR_DATA_W,
  parameter int LOG2_N     = 3,
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     sample_in,
  input  logic                  sample_en,
  output logic [DATA_W-1:0]     avg_out,
  output logic                  avg_valid,
  input  logic                  avg_ready,
  output logic                  busy,
`ifdef SENSOR_WINDOW_MINMAX_EN
  output logic [DATA_W-1:0]     min_out,
  output logic [DATA_W-1:0]     max_out,
`endif
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};

  buf_state_e             buf_state_q, buf_state_d;
  window_result_t         res_q, res_d, win_res_s;
  logic [DROP_CNT_W-1:0]  drop_q, drop_d;
  logic                   done_s;

  sensor_window_accum #(
    .LOG2_N (LOG2_N)
  ) u_accum (
    .clk         (clk),
    .reset       (reset),
    .sample_in_i (sample_in),
    .sample_en_i (sample_en),
    .busy_o      (busy),
    .done_o      (done_s),
    .result_o    (win_res_s)
  );

  assign avg_valid = (buf_state_q == BUF_FULL);
  assign avg_out   = res_q.avg;
  assign drop_cnt  = drop_q;
`ifdef SENSOR_WINDOW_MINMAX_EN
  assign min_out   = res_q.min;
  assign max_out   = res_q.max;
`endif

  // Buffer load/drain; a completion into a full, stalled buffer is counted and lost.
  always_comb begin
    buf_state_d = buf_state_q;
    res_d       = res_q;
    drop_d      = drop_q;
    case (buf_state_q)
      BUF_EMPTY: begin
        if (done_s) begin
          res_d       = win_res_s;
          buf_state_d = BUF_FULL;
        end else begin
          buf_state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (done_s && avg_ready) begin
          res_d       = win_res_s;
          buf_state_d = BUF_FULL;
        end else if (done_s) begin
          drop_d      = (drop_q == DROP_MAX) ? drop_q : drop_q + 1'b1;
        end else if (avg_ready) begin
          buf_state_d = BUF_EMPTY;
        end else begin
          buf_state_d = BUF_FULL;
        end
      end
      default: begin
        buf_state_d = BUF_EMPTY;
      end
    endcase
  end

  // Output buffer and drop counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_state_q <= BUF_EMPTY;
      res_q       <= '0;
      drop_q      <= '0;
    end else begin
      buf_state_q <= buf_state_d;
      res_q       <= res_d;
      drop_q      <= drop_d;
    end
  end

endmodule

// File: tb/tb_sensor_window_averager.sv
// Directed self-checking bench for sensor_window_averager (LOG2_N=3).
module tb_sensor_window_averager;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sample_in;
  logic       sample_en;
  logic [7:0] avg_out;
  logic       avg_valid;
  logic       avg_ready;
  logic       busy;
  logic [7:0] drop_cnt;
`ifdef SENSOR_WINDOW_MINMAX_EN
  logic [7:0] min_out;
  logic [7:0] max_out;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sensor_window_averager #(
    .DATA_W     (8),
    .LOG2_N     (3),
    .DROP_CNT_W (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sample_in (sample_in),
    .sample_en (sample_en),
    .avg_out   (avg_out),
    .avg_valid (avg_valid),
    .avg_ready (avg_ready),
    .busy      (busy),
`ifdef SENSOR_WINDOW_MINMAX_EN
    .min_out   (min_out),
    .max_out   (max_out),
`endif
    .drop_cnt  (drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one qualified sample; returns #1 after the edge that consumes it.
  task automatic send(input logic [7:0] v);
    sample_in = v;
    sample_en = 1'b1;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset     = 1'b1;
    sample_in = 8'd0;
    sample_en = 1'b0;
    avg_ready = 1'b0;
    idle(2);
    reset = 1'b0;
    check("rst_avg", avg_out, 0);
    check("rst_valid", avg_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_cnt, 0);

    // Ramp 10..80, mean 45
    avg_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(8'(i * 10));
      if (i == 5) check("ramp_busy", busy, 1);
      if (i == 7) check("ramp_not_done", avg_valid, 0);
    end
    check("ramp_valid", avg_valid, 1);
    check("ramp_avg", avg_out, 45);
    check("ramp_busy_end", busy, 0);
    check("ramp_drop", drop_cnt, 0);
    idle(1);
    check("ramp_drain", avg_valid, 0);

    // Full-scale window
    for (int i = 0; i < 8; i++) send(8'd255);
    check("max_avg", avg_out, 255);
    check("max_valid", avg_valid, 1);
    idle(1);

    // 9/8 truncates to 1
    for (int i = 0; i < 7; i++) send(8'd1);
    send(8'd2);
    check("trunc_avg", avg_out, 1);
    idle(1);

    // Three windows under back-pressure: first held, two dropped
    avg_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'd16);
    check("bp_first", avg_out, 16);
    for (int i = 0; i < 8; i++) send(8'd32);
    check("bp_hold1", avg_out, 16);
    check("bp_drop1", drop_cnt, 1);
    for (int i = 0; i < 8; i++) send(8'd48);
    check("bp_hold2", avg_out, 16);
    check("bp_valid", avg_valid, 1);
    check("bp_drop2", drop_cnt, 2);
    avg_ready = 1'b1;
    idle(1);
    check("bp_release", avg_valid, 0);

    // Handshake and completion on the same edge: no bubble, no drop
    avg_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'd50);
    check("same_first", avg_out, 50);
    for (int i = 0; i < 7; i++) send(8'd60);
    check("same_hold", avg_out, 50);
    avg_ready = 1'b1;
    send(8'd60);
    check("same_avg", avg_out, 60);
    check("same_valid", avg_valid, 1);
    check("same_drop", drop_cnt, 2);
    idle(1);
    check("same_drain", avg_valid, 0);

    // Reset mid-window discards the partial sum and the drop count
    for (int i = 0; i < 5; i++) send(8'd200);
    check("part_busy", busy, 1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("part_rst_busy", busy, 0);
    check("part_rst_drop", drop_cnt, 0);
    check("part_rst_valid", avg_valid, 0);
    for (int i = 0; i < 8; i++) send(8'd100);
    check("part_avg", avg_out, 100);
    idle(1);

    // Gapped samples: seven zeros and an 8 give mean 1
    for (int i = 0; i < 7; i++) begin
      send(8'd0);
      idle(2);
    end
    check("gap_busy", busy, 1);
    check("gap_valid", avg_valid, 0);
    send(8'd8);
    check("gap_avg", avg_out, 1);
    check("gap_valid_end", avg_valid, 1);
    idle(1);

    // Mixed window: mean 44/8 = 5, min 3, max 9
    send(8'd7);
    send(8'd3);
    send(8'd9);
    for (int i = 0; i < 5; i++) send(8'd5);
    check("mm_avg", avg_out, 5);
`ifdef SENSOR_WINDOW_MINMAX_EN
    check("mm_min", min_out, 3);
    check("mm_max", max_out, 9);
    idle(1);
    for (int i = 0; i < 8; i++) send(8'd20);
    check("mm_reseed_min", min_out, 20);
    check("mm_reseed_max", max_out, 20);
`endif
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
